// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, operand addresses and FSM states for the host command responder.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        ALU_FUNC,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } state_t;

endpackage

// File: rtl/sys_ctrl_cmd_responder.sv
// Parses host command bytes, strobes the regfile/ALU and returns read data or ALU results
// as TX bytes. All outputs come straight from flops.
module sys_ctrl_cmd_responder
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int FUNC_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [ADDR_SIZE-1:0]     RF_Address,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_VLD,
    output logic                     ALU_EN,
    output logic [FUNC_WIDTH-1:0]    ALU_FUN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_BUSY,
    output logic                     CMD_ERR
);

    localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);

    state_t                   state_reg;
    logic [ADDR_SIZE-1:0]     wr_addr_reg;
    logic [TMR_W-1:0]         timer_reg;
    logic [ALU_OUT_WIDTH-1:0] result_reg;
    logic                     two_byte_reg;
    logic                     timeout;

    // Timer restarts at 0 on wait entry, so this fires after WAIT_TIMEOUT wait cycles.
    assign timeout = (timer_reg == TMR_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg    <= IDLE;
            wr_addr_reg  <= '0;
            timer_reg    <= '0;
            result_reg   <= '0;
            two_byte_reg <= 1'b0;
            RF_WrEn      <= 1'b0;
            RF_RdEn      <= 1'b0;
            RF_Address   <= '0;
            RF_WrData    <= '0;
            ALU_EN       <= 1'b0;
            ALU_FUN      <= '0;
            CLK_GATE_EN  <= 1'b0;
            TX_P_DATA    <= '0;
            TX_D_VLD     <= 1'b0;
            CMD_ERR      <= 1'b0;
        end else begin
            RF_WrEn  <= 1'b0;
            RF_RdEn  <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;
            CMD_ERR  <= 1'b0;

            if (state_reg == RD_WAIT || state_reg == ALU_WAIT) begin
                timer_reg <= timer_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            DATA_WIDTH'(CMD_RF_WR):   state_reg <= WR_ADDR;
                            DATA_WIDTH'(CMD_RF_RD):   state_reg <= RD_ADDR;
                            DATA_WIDTH'(CMD_ALU_OP):  state_reg <= OP_A;
                            DATA_WIDTH'(CMD_ALU_NOP): begin
                                state_reg   <= ALU_FUNC;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default:                  CMD_ERR <= 1'b1;
                        endcase
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        wr_addr_reg <= RX_P_DATA[ADDR_SIZE-1:0];
                        state_reg   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= wr_addr_reg;
                        RF_WrData  <= RX_P_DATA;
                        state_reg  <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_RdEn    <= 1'b1;
                        RF_Address <= RX_P_DATA[ADDR_SIZE-1:0];
                        timer_reg  <= '0;
                        state_reg  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (RF_RdData_VLD) begin
                        result_reg   <= ALU_OUT_WIDTH'(RF_RdData);
                        two_byte_reg <= 1'b0;
                        state_reg    <= TX_LO;
                    end else if (timeout) begin
                        CMD_ERR   <= 1'b1;
                        state_reg <= IDLE;
                    end
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                end
                OP_A: begin
                    if (RX_D_VLD) begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= ADDR_SIZE'(OPA_ADDR);
                        RF_WrData  <= RX_P_DATA;
                        state_reg  <= OP_B;
                    end
                end
                OP_B: begin
                    if (RX_D_VLD) begin
                        RF_WrEn     <= 1'b1;
                        RF_Address  <= ADDR_SIZE'(OPB_ADDR);
                        RF_WrData   <= RX_P_DATA;
                        CLK_GATE_EN <= 1'b1;
                        state_reg   <= ALU_FUNC;
                    end
                end
                ALU_FUNC: begin
                    if (RX_D_VLD) begin
                        ALU_FUN   <= RX_P_DATA[FUNC_WIDTH-1:0];
                        ALU_EN    <= 1'b1;
                        timer_reg <= '0;
                        state_reg <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        result_reg   <= ALU_OUT;
                        two_byte_reg <= 1'b1;
                        CLK_GATE_EN  <= 1'b0;
                        state_reg    <= TX_LO;
                    end else if (timeout) begin
                        CMD_ERR     <= 1'b1;
                        CLK_GATE_EN <= 1'b0;
                        state_reg   <= IDLE;
                    end
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                end
                TX_LO: begin
                    if (!TX_BUSY) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= result_reg[DATA_WIDTH-1:0];
                        state_reg <= two_byte_reg ? TX_HI : IDLE;
                    end
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                end
                TX_HI: begin
                    if (!TX_BUSY) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= result_reg[DATA_WIDTH +: DATA_WIDTH];
                        state_reg <= IDLE;
                    end
                    if (RX_D_VLD) CMD_ERR <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_cmd_responder.sv
// Randomized and directed check of the command responder against a transaction-level model
// with simple regfile, ALU and TX FIFO responders around the DUT.
module tb_sys_ctrl_cmd_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic        RF_WrEn, RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData = '0;
    logic        RF_RdData_VLD = 1'b0;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY = 1'b0;
    logic        CMD_ERR;

    sys_ctrl_cmd_responder dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Observed activity
    logic [11:0] obs_wr[$];
    logic [3:0]  obs_rd[$];
    logic [3:0]  obs_alu[$];
    logic [7:0]  obs_tx[$];
    int          obs_tx_cyc[$];
    int          obs_err = 0;
    int          last_rd_cyc = 0;
    int          last_err_cyc = 0;
    int          overlap_cnt = 0;
    int          gate_bad = 0;
    logic        gate_prev = 1'b0;
    int          cyc = 0;

    // Expected activity
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_tx[$];
    int          exp_err = 0;
    logic [7:0]  exp_mem[16];

    // Environment state
    logic [7:0]  rf[16];
    logic [3:0]  rd_a;
    logic [15:0] alu_r;
    int          alu_delay = 2;
    bit          rd_suppress = 0;
    bit          rand_busy_en = 0;
    bit          arm_busy = 0;
    int          busy_cnt = 0;
    int          gap = 0;

    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return (b != 0) ? 16'(a / b) : 16'h0000;
            default: return {8'h00, a & b};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: outputs settle after posedge, so sample on negedge.
    always @(negedge CLK) begin
        cyc++;
        if (RF_WrEn) begin
            obs_wr.push_back({RF_Address, RF_WrData});
            rf[RF_Address] = RF_WrData;
        end
        if (RF_RdEn) begin
            obs_rd.push_back(RF_Address);
            last_rd_cyc = cyc;
        end
        if (RF_WrEn && RF_RdEn) overlap_cnt++;
        if (ALU_EN) begin
            obs_alu.push_back(ALU_FUN);
            if (!(CLK_GATE_EN && gate_prev)) gate_bad++;
        end
        gate_prev = CLK_GATE_EN;
        if (TX_D_VLD) begin
            obs_tx.push_back(TX_P_DATA);
            obs_tx_cyc.push_back(cyc);
        end
        if (CMD_ERR) begin
            obs_err++;
            last_err_cyc = cyc;
        end
    end

    // Regfile: read data one cycle after the read strobe.
    always begin
        @(negedge CLK);
        if (RF_RdEn && !rd_suppress) begin
            rd_a = RF_Address;
            @(negedge CLK);
            RF_RdData = rf[rd_a];
            RF_RdData_VLD = 1'b1;
            @(negedge CLK);
            RF_RdData_VLD = 1'b0;
            RF_RdData = '0;
        end
    end

    // ALU: result alu_delay cycles after the start strobe.
    always begin
        @(negedge CLK);
        if (ALU_EN) begin
            alu_r = alu_calc(rf[0], rf[1], ALU_FUN);
            repeat (alu_delay) @(negedge CLK);
            ALU_OUT = alu_r;
            ALU_OUT_VLD = 1'b1;
            @(negedge CLK);
            ALU_OUT_VLD = 1'b0;
        end
    end

    // TX FIFO: random back-pressure, or a 10-cycle full window after an armed byte.
    always @(negedge CLK) begin
        if (busy_cnt > 0) busy_cnt--;
        else if (arm_busy && TX_D_VLD) begin
            busy_cnt = 10;
            arm_busy = 0;
        end
        TX_BUSY = (busy_cnt > 0) || (rand_busy_en && ($urandom_range(0, 3) == 0));
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({a[3:0], d});
        exp_mem[a[3:0]] = d;
    endtask

    task automatic m_read(input logic [7:0] a);
        exp_rd.push_back(a[3:0]);
        exp_tx.push_back(exp_mem[a[3:0]]);
    endtask

    task automatic m_alu(input logic [7:0] f);
        logic [15:0] r;
        r = alu_calc(exp_mem[0], exp_mem[1], f[3:0]);
        exp_alu.push_back(f[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hAA); send_byte(a); send_byte(d);
        m_write(a, d);
    endtask

    task automatic do_read(input logic [7:0] a);
        send_byte(8'hBB); send_byte(a);
        m_read(a);
    endtask

    task automatic do_alu_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] f);
        send_byte(8'hCC); send_byte(x); send_byte(y); send_byte(f);
        m_write(8'd0, x); m_write(8'd1, y); m_alu(f);
    endtask

    task automatic do_alu_nop(input logic [7:0] f);
        send_byte(8'hDD); send_byte(f);
        m_alu(f);
    endtask

    task automatic finish_txn(input string tag);
        int n = 0;
        while (n < 600 && (obs_tx.size() < exp_tx.size() || obs_wr.size() < exp_wr.size() ||
               obs_rd.size() < exp_rd.size() || obs_alu.size() < exp_alu.size() ||
               obs_err < exp_err)) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        chk({tag, "_in_time"}, 32'(n < 600), 1);
        chk({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 32'(obs_wr[i]), 32'(exp_wr[i]));
        chk({tag, "_nrd"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i), 32'(obs_rd[i]), 32'(exp_rd[i]));
        chk({tag, "_nalu"}, obs_alu.size(), exp_alu.size());
        for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++)
            chk($sformatf("%s_fun%0d", tag, i), 32'(obs_alu[i]), 32'(exp_alu[i]));
        chk({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), 32'(obs_tx[i]), 32'(exp_tx[i]));
        chk({tag, "_err"}, obs_err, exp_err);
        chk({tag, "_gate_idle"}, 32'(CLK_GATE_EN), 0);
        $display("txn %s: wr=%0d rd=%0d alu=%0d tx=%0d err=%0d", tag, obs_wr.size(),
                 obs_rd.size(), obs_alu.size(), obs_tx.size(), obs_err);
        obs_wr.delete(); obs_rd.delete(); obs_alu.delete(); obs_tx.delete();
        exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
        obs_err = 0;
        exp_err = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int kind;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = '0;
            rf[i] = '0;
        end

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_wren",  32'(RF_WrEn), 0);
        chk("rst_rden",  32'(RF_RdEn), 0);
        chk("rst_addr",  32'(RF_Address), 0);
        chk("rst_wdata", 32'(RF_WrData), 0);
        chk("rst_alu_en", 32'(ALU_EN), 0);
        chk("rst_fun",   32'(ALU_FUN), 0);
        chk("rst_gate",  32'(CLK_GATE_EN), 0);
        chk("rst_txd",   32'(TX_P_DATA), 0);
        chk("rst_txv",   32'(TX_D_VLD), 0);
        chk("rst_err",   32'(CMD_ERR), 0);
        RST = 1'b1;
        @(negedge CLK);

        do_write(8'h04, 8'h09);             finish_txn("write");
        do_read(8'h04);                     finish_txn("read");
        do_alu_op(8'h3C, 8'h32, 8'h02);     finish_txn("alu_op");

        obs_tx_cyc.delete();
        arm_busy = 1;
        do_alu_nop(8'h01);                  finish_txn("alu_nop_busy");
        chk("busy_ntx", obs_tx_cyc.size(), 2);
        if (obs_tx_cyc.size() >= 2)
            chk("busy_gap", obs_tx_cyc[1] - obs_tx_cyc[0], 11);

        send_byte(8'h55); exp_err = 1;      finish_txn("bad_opcode");

        rd_suppress = 1;
        send_byte(8'hBB); send_byte(8'h04);
        exp_rd.push_back(4'h4);
        exp_err = 1;
        finish_txn("rd_timeout");
        chk("timeout_gap", last_err_cyc - last_rd_cyc, 255);
        rd_suppress = 0;

        alu_delay = 8;
        do_alu_op(8'h11, 8'h22, 8'h00);
        send_byte(8'h77);
        exp_err = 1;
        finish_txn("alu_wait_extra");

        send_byte(8'hAA); send_byte(8'h04);
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); RST = 1'b1;
        finish_txn("reset_mid");
        do_read(8'h04);                     finish_txn("read_after_rst");

        rand_busy_en = 1;
        for (int t = 0; t < 40; t++) begin
            gap = $urandom_range(0, 2);
            alu_delay = $urandom_range(1, 6);
            kind = $urandom_range(0, 4);
            case (kind)
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom));
                2: do_alu_op(8'($urandom), 8'($urandom), 8'($urandom_range(0, 5)));
                3: do_alu_nop(8'($urandom_range(0, 5)));
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
                    send_byte(b);
                    exp_err = 1;
                end
            endcase
            finish_txn($sformatf("rand%0d_k%0d", t, kind));
        end
        rand_busy_en = 0;

        chk("no_wr_rd_overlap", overlap_cnt, 0);
        chk("gate_before_alu_en", gate_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
